maverickone_exe_mult_acc: RTL and testbench

- Second stage of the maverickOne multiplier, directly downstream of the multiple-precompute stage.
- Consumes the 16-entry table of rs1 multiples (0·rs1 .. 15·rs1) plus rs1, rs2 and the op select.
- Iterates over rs2 in radix-16 digits, one digit per cycle, accumulating shifted table entries.
- Applies signed correction and delivers the RV64M result (MUL/MULH/MULHSU/MULHU/MULW) to writeback over a valid/ready handshake.

---
 rtl/maverickone_exe_mult_acc.sv | 142 ++++++++++++++
 tb/tb_maverickone_exe_mult_acc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/maverickone_exe_mult_acc.sv
// maverickOne multiplier stage 2: radix-16 digit-serial accumulate over a precomputed rs1 multiple table.
// Optional early exit on trailing zero rs2 digits: define MAVERICKONE_MULT_EARLY_EXIT_EN.
package maverickOne_pkg;
   localparam int XLEN = 64;
endpackage

module maverickone_exe_mult_acc
   import maverickOne_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      arst_ni,
   input  logic                      flush_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [16*(XLEN+4)-1:0]    multiples_i,
   input  logic [XLEN-1:0]           rs1_i,
   input  logic [XLEN-1:0]           rs2_i,
   input  logic                      MUL_i,
   input  logic                      MULH_i,
   input  logic                      MULHSU_i,
   input  logic                      MULHU_i,
   input  logic                      MULW_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [XLEN-1:0]           rd_o
);
   localparam int MW  = XLEN + 4;
   localparam int ND  = XLEN / 4;
   localparam int CW  = $clog2(ND);
   localparam int SHW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW} op_e;

   state_e                 state;
   op_e                    op_q, op_dec;
   logic [15:0][MW-1:0]    mult_q;
   logic [XLEN-1:0]        rs1_q, rs2_q;
   logic [2*XLEN-1:0]      acc;
   logic [CW-1:0]          cnt;

   logic [4:0]             sel;
   logic [SHW-1:0]         sh;
   logic [3:0]             dig;
   logic [MW-1:0]          entry;
   logic [2*XLEN-1:0]      addend, acc_nxt, corr;
   logic [XLEN-1:0]        rs2_rng, res;
   logic [CW-1:0]          cnt_last;
   logic                   last;

   assign sel = {MULW_i, MULHU_i, MULHSU_i, MULH_i, MUL_i};

   // Illegal (zero / multi-hot) selects fall back to MUL.
   always_comb begin
      op_dec = OP_MUL;
      case (sel)
         5'b00010: op_dec = OP_MULH;
         5'b00100: op_dec = OP_MULHSU;
         5'b01000: op_dec = OP_MULHU;
         5'b10000: op_dec = OP_MULW;
         default:  op_dec = OP_MUL;
      endcase
   end

   always_comb begin
      sh       = SHW'({cnt, 2'b00});
      dig      = 4'(rs2_q >> sh);
      entry    = mult_q[dig];
      addend   = (2*XLEN)'(entry) << sh;
      acc_nxt  = acc + addend;
      cnt_last = (op_q == OP_MULW) ? CW'(7) : CW'(ND-1);
      rs2_rng  = (op_q == OP_MULW) ? {{(XLEN-32){1'b0}}, rs2_q[31:0]} : rs2_q;
      last     = (cnt == cnt_last);
`ifdef MAVERICKONE_MULT_EARLY_EXIT_EN
      if ((rs2_rng >> (sh + SHW'(4))) == '0) last = 1'b1;
`endif
      // Unsigned product minus the two's-complement sign terms gives the signed high half.
      corr = acc_nxt;
      if ((op_q == OP_MULH || op_q == OP_MULHSU) && rs1_q[XLEN-1])
         corr = corr - {rs2_q, {XLEN{1'b0}}};
      if (op_q == OP_MULH && rs2_q[XLEN-1])
         corr = corr - {rs1_q, {XLEN{1'b0}}};
      case (op_q)
         OP_MUL:  res = acc_nxt[XLEN-1:0];
         OP_MULW: res = {{(XLEN-32){acc_nxt[31]}}, acc_nxt[31:0]};
         default: res = corr[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state   <= IDLE;
         op_q    <= OP_MUL;
         mult_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         acc     <= '0;
         cnt     <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
         rd_o    <= '0;
      end else if (flush_i) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_i) begin
               mult_q  <= multiples_i;
               rs1_q   <= rs1_i;
               rs2_q   <= rs2_i;
               op_q    <= op_dec;
               acc     <= '0;
               cnt     <= '0;
               ready_o <= 1'b0;
               state   <= RUN;
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  rd_o    <= res;
                  valid_o <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: if (ready_i) begin
               valid_o <= 1'b0;
               ready_o <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_onehot_op: assert property (@(posedge clk_i) disable iff (!arst_ni)
      (valid_i && ready_o && !flush_i) |-> $onehot(sel));

endmodule

// File: tb/tb_maverickone_exe_mult_acc.sv
// Directed bench for maverickone_exe_mult_acc with a result scoreboard and independent 128-bit product model.
module tb_maverickone_exe_mult_acc;
   localparam int XLEN = 64;
   localparam int MW   = XLEN + 4;

   logic              clk = 1'b0;
   logic              arst_ni, flush_i, valid_i, ready_o, valid_o, ready_i;
   logic [16*MW-1:0]  multiples_i;
   logic [XLEN-1:0]   rs1_i, rs2_i, rd_o;
   logic              MUL_i, MULH_i, MULHSU_i, MULHU_i, MULW_i;

   always #5 clk = ~clk;

   maverickone_exe_mult_acc dut (
      .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .multiples_i(multiples_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .MUL_i(MUL_i), .MULH_i(MULH_i), .MULHSU_i(MULHSU_i), .MULHU_i(MULHU_i), .MULW_i(MULW_i),
      .valid_o(valid_o), .ready_i(ready_i), .rd_o(rd_o)
   );

   typedef struct { logic [63:0] rd; int lat; } exp_t;
   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3, OP_MULW = 4;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [16*MW-1:0] mk_mult(input logic [63:0] a);
      logic [16*MW-1:0] m;
      for (int k = 0; k < 16; k++) m[k*MW +: MW] = {4'b0, a} * MW'(k);
      return m;
   endfunction

   function automatic logic [63:0] ref_rd(input int op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      case (op)
         OP_MULH:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
         OP_MULHSU: p = {{64{a[63]}}, a} * {64'b0, b};
         default:   p = {64'b0, a} * {64'b0, b};
      endcase
      case (op)
         OP_MUL:  return p[63:0];
         OP_MULW: return {{32{p[31]}}, p[31:0]};
         default: return p[127:64];
      endcase
   endfunction

   function automatic int exp_lat(input int op, input logic [63:0] b);
      int nd;
      int h;
      nd = (op == OP_MULW) ? 8 : 16;
`ifdef MAVERICKONE_MULT_EARLY_EXIT_EN
      h = 0;
      for (int i = 0; i < nd; i++) if (b[4*i +: 4] != 4'h0) h = i;
      return h + 2;
`else
      h = nd;
      return h + 1;
`endif
   endfunction

   task automatic drive(input int op, input logic [63:0] a, input logic [63:0] b);
      logic [4:0] s;
      s = 5'b00001 << op;
      {MULW_i, MULHU_i, MULHSU_i, MULH_i, MUL_i} = s;
      multiples_i = mk_mult(a);
      rs1_i = a;
      rs2_i = b;
      valid_i = 1'b1;
   endtask

   // Issue one op, measure accept->valid latency, compare against scoreboard head.
   task automatic run_op(input int op, input logic [63:0] a, input logic [63:0] b, input string tag);
      int lat;
      exp_t e;
      sb.push_back('{ref_rd(op, a, b), exp_lat(op, b)});
      @(negedge clk);
      drive(op, a, b);
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
      chk({tag, "_rd"}, rd_o, e.rd);
      if (ready_i) begin
         @(posedge clk); #1;
         chk({tag, "_vld_drop"}, 64'(valid_o), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] hold_rd;
      int seen;
      arst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      multiples_i = '0; rs1_i = '0; rs2_i = '0;
      {MULW_i, MULHU_i, MULHSU_i, MULH_i, MUL_i} = 5'b00001;
      #12;
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_rd", rd_o, 64'd0);
      @(negedge clk); arst_ni = 1'b1;

      run_op(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mulhu_max");
      run_op(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3, "mulh_m2x3");
      run_op(OP_MUL,    64'hFFFF_FFFF_FFFF_FFFE, 64'd3, "mul_m2x3");
      run_op(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1");
      run_op(OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, "mulw_ovf");
      run_op(OP_MUL,    64'd9, 64'h12, "mul_9x12");
      run_op(OP_MUL,    64'h1234_5678_9ABC_DEF0, 64'd0, "mul_zero");
      run_op(OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "mulh_minmin");
      for (int i = 0; i < 4; i++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         run_op(i % 5, a, b, "rand");
      end

      // Result back-pressure
      ready_i = 1'b0;
      run_op(OP_MULHU, 64'hDEAD_BEEF_0000_1111, 64'hCAFE_0000_F00D_0001, "bp");
      hold_rd = rd_o;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 64'(valid_o), 64'd1);
         chk("bp_rd", rd_o, hold_rd);
         chk("bp_ready", 64'(ready_o), 64'd0);
      end
      ready_i = 1'b1;
      @(posedge clk); #1;
      chk("bp_rel_valid", 64'(valid_o), 64'd0);
      chk("bp_rel_ready", 64'(ready_o), 64'd1);

      // Flush mid-run; valid_i held with flush in IDLE must not be accepted
      @(negedge clk);
      drive(OP_MUL, 64'd123, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      flush_i = 1'b1;
      valid_i = 1'b1;
      @(posedge clk); #1;
      chk("flush_valid", 64'(valid_o), 64'd0);
      chk("flush_ready", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_noacc", 64'(ready_o), 64'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid_o) seen++;
      end
      chk("flush_noresult", 64'(seen), 64'd0);
      run_op(OP_MUL, 64'd5, 64'd7, "post_flush");

      // Reset mid-run
      @(negedge clk);
      drive(OP_MULH, 64'h7777_0000_0000_0001, 64'h1111_0000_0000_0003);
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst_ni = 1'b0;
      #1;
      chk("mrst_ready", 64'(ready_o), 64'd1);
      chk("mrst_valid", 64'(valid_o), 64'd0);
      chk("mrst_rd", rd_o, 64'd0);
      @(negedge clk); arst_ni = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid_o) seen++;
      end
      chk("mrst_noresult", 64'(seen), 64'd0);
      run_op(OP_MULW, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "mulw_post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
